ahb_lite_ram_port: RTL and testbench

AHB_LITE_RAM_PORT -- requirements
Module: ahb_lite_ram_port

---
 rtl/ahb_lite_ram_port_if.sv | 23 ++
 rtl/ahb_lite_ram_port.sv | 116 +++++++++++
 tb/tb_ahb_lite_ram_port.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_ram_port_if.sv
// AHB-Lite bus bundle between a master and the RAM port slave.
// The master drives the address/control and write data; the slave returns read data and response.
interface ahb_lite_ram_port_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_ram_port.sv
// Zero-wait-state AHB-Lite slave in front of four byte-lane synchronous RAMs,
// with a one-shot read-after-write bypass and a two-cycle ERROR response.
module ahb_lite_ram_port #(
  parameter int RAM_ADDR_WIDTH = 6
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  ahb_lite_ram_port_if.slave        ahb,
  output logic [RAM_ADDR_WIDTH-1:0] ram_read_addr,
  output logic [RAM_ADDR_WIDTH-1:0] ram_write_addr,
  output logic [31:0]               ram_wdata,
  output logic [3:0]                ram_we,
  input  logic [31:0]               ram_rdata
);

  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_hready;
  logic                      w_hresp;
  logic                      w_accept;
  logic                      w_legal;
  logic [3:0]                w_mask;
  logic [RAM_ADDR_WIDTH-1:0] w_word;
  logic                      w_byp_hit;
  logic [31:0]               w_hrdata;

  logic                      r_wr_pend;
  logic [RAM_ADDR_WIDTH-1:0] r_waddr;
  logic [3:0]                r_mask;
  logic                      r_byp_vld;
  logic [3:0]                r_byp_mask;
  logic [31:0]               r_byp_data;

  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0:    byte_mask = 4'b0001 << off;
      3'd1:    byte_mask = 4'b0011 << off;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0:    is_legal = 1'b1;
      3'd1:    is_legal = ~off[0];
      3'd2:    is_legal = (off == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

  // Upper HADDR bits are dropped here, which makes the RAM alias across the map.
  assign w_word    = ahb.HADDR[RAM_ADDR_WIDTH+1:2];
  assign w_hready  = (r_state != ST_ERR1);
  assign w_hresp   = (r_state != ST_OKAY);
  assign w_accept  = ahb.HSEL & ahb.HTRANS[1] & w_hready;
  assign w_legal   = is_legal(ahb.HSIZE, ahb.HADDR[1:0]);
  assign w_mask    = byte_mask(ahb.HSIZE, ahb.HADDR[1:0]);
  assign w_byp_hit = r_wr_pend & w_accept & w_legal & ~ahb.HWRITE & (w_word == r_waddr);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OKAY: if (w_accept && !w_legal) w_state_nxt = ST_ERR1;
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_ERR2: w_state_nxt = (w_accept && !w_legal) ? ST_ERR1 : ST_OKAY;
      default: w_state_nxt = ST_OKAY;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_OKAY;
      r_wr_pend  <= 1'b0;
      r_waddr    <= '0;
      r_mask     <= 4'b0000;
      r_byp_vld  <= 1'b0;
      r_byp_mask <= 4'b0000;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_pend <= w_accept & w_legal & ahb.HWRITE;
      if (w_accept && w_legal) begin
        r_waddr <= w_word;
        r_mask  <= w_mask;
      end
      r_byp_vld <= w_byp_hit;
      if (w_byp_hit) r_byp_mask <= r_mask;
    end
  end

  // Bypass data is qualified by r_byp_vld, so it needs no reset.
  always_ff @(posedge HCLK) begin
    if (w_byp_hit) r_byp_data <= ahb.HWDATA;
  end

  always_comb begin
    w_hrdata = ram_rdata;
    if (r_byp_vld) begin
      for (int i = 0; i < 4; i++) begin
        if (r_byp_mask[i]) w_hrdata[8*i +: 8] = r_byp_data[8*i +: 8];
      end
    end
  end

  // ram_we follows the async-cleared pending flag, so reset kills a write mid-phase.
  assign ram_we         = r_wr_pend ? r_mask : 4'b0000;
  assign ram_write_addr = r_waddr;
  assign ram_wdata      = ahb.HWDATA;
  assign ram_read_addr  = w_word;

  assign ahb.HRDATA = w_hrdata;
  assign ahb.HREADY = w_hready;
  assign ahb.HRESP  = w_hresp;

endmodule

// File: tb/tb_ahb_lite_ram_port.sv
// Bench for ahb_lite_ram_port: byte-lane RAM, transaction-level reference memory,
// directed scenarios and randomized AHB-Lite traffic.
module tb_ahb_lite_ram_port;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic [5:0]  ram_read_addr;
  logic [5:0]  ram_write_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_lite_ram_port_if bus ();

  ahb_lite_ram_port #(.RAM_ADDR_WIDTH(6)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .ahb           (bus),
    .ram_read_addr (ram_read_addr),
    .ram_write_addr(ram_write_addr),
    .ram_wdata     (ram_wdata),
    .ram_we        (ram_we),
    .ram_rdata     (ram_rdata)
  );

  always #5 HCLK = ~HCLK;

  // Four byte-lane synchronous RAMs: one-cycle read latency, old data on same-cycle write.
  logic [31:0] ram_mem [64] = '{default: 32'h0};
  always @(posedge HCLK) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) ram_mem[ram_write_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
    ram_rdata <= ram_mem[ram_read_addr];
  end

  // Reference: memory as seen by the bus master after every completed write,
  // plus what the current data phase is and how many error cycles remain.
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  int          m_err      = 0;
  logic        m_dp_valid = 1'b0;
  logic        m_dp_write = 1'b0;
  logic [5:0]  m_dp_addr  = 6'd0;
  logic [3:0]  m_dp_mask  = 4'd0;

  function automatic logic ref_legal(input logic [2:0] sz, input logic [31:0] a);
    int bytes;
    if (sz > 3'd2) return 1'b0;
    bytes = 1 << sz;
    return (int'(a[1:0]) % bytes) == 0;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] sz, input logic [31:0] a);
    logic [3:0] m;
    int off;
    int bytes;
    off   = int'(a[1:0]);
    bytes = 1 << sz;
    for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + bytes);
    return m;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin : model
    logic        acc;
    logic        leg;
    logic [31:0] w;
    if (!HRESETn) begin
      m_err      <= 0;
      m_dp_valid <= 1'b0;
      m_dp_write <= 1'b0;
    end else begin
      if (m_dp_valid && m_dp_write) begin
        w = ref_mem[m_dp_addr];
        for (int i = 0; i < 4; i++) begin
          if (m_dp_mask[i]) w[8*i +: 8] = bus.HWDATA[8*i +: 8];
        end
        ref_mem[m_dp_addr] <= w;
      end
      acc = bus.HSEL && bus.HTRANS[1] && (m_err != 2);
      leg = ref_legal(bus.HSIZE, bus.HADDR);
      m_dp_valid <= acc && leg;
      m_dp_write <= bus.HWRITE;
      m_dp_addr  <= bus.HADDR[7:2];
      m_dp_mask  <= ref_mask(bus.HSIZE, bus.HADDR);
      if (acc && !leg)  m_err <= 2;
      else if (m_err > 0) m_err <= m_err - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin : compare
    logic [3:0] exp_we;
    exp_we = (m_dp_valid && m_dp_write) ? m_dp_mask : 4'b0000;
    chk("HREADY", bus.HREADY, (m_err != 2));
    chk("HRESP", bus.HRESP, (m_err != 0));
    chk("ram_we", ram_we, exp_we);
    chk("ram_read_addr", ram_read_addr, bus.HADDR[7:2]);
    if (exp_we != 4'b0000) begin
      chk("ram_write_addr", ram_write_addr, m_dp_addr);
      chk("ram_wdata", ram_wdata, bus.HWDATA);
    end
    if (m_dp_valid && !m_dp_write) chk("HRDATA", bus.HRDATA, ref_mem[m_dp_addr]);
  end

  task automatic set_bus(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bus.HSEL   = sel;
    bus.HTRANS = tr;
    bus.HWRITE = wr;
    bus.HSIZE  = sz;
    bus.HADDR  = a;
    bus.HWDATA = wd;
  endtask

  // One bus cycle: drive just after the rising edge, return at the falling edge.
  task automatic ap(input logic sel, input logic [1:0] tr, input logic wr,
                    input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    @(posedge HCLK);
    #1;
    set_bus(sel, tr, wr, sz, a, wd);
    @(negedge HCLK);
  endtask

  initial begin
    logic [2:0]  sz;
    logic [1:0]  off;
    logic [31:0] a;

    set_bus(1'b0, IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    #1 HRESETn = 1'b0;
    #2;
    chk("rst_hready", bus.HREADY, 1);
    chk("rst_hresp", bus.HRESP, 0);
    chk("rst_we", ram_we, 4'b0000);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    set_bus(1'b1, IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge HCLK);
    chk("idle_hready", bus.HREADY, 1);
    ap(1'b1, IDLE, 1'b1, 3'd2, 32'h0, 32'h0);
    chk("idle_hresp", bus.HRESP, 0);
    chk("idle_we", ram_we, 4'b0000);

    // Read-after-write bypass
    ap(1'b1, NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0);
    ap(1'b1, NONSEQ, 1'b0, 3'd2, 32'h10, 32'h12345678);
    chk("raw_we", ram_we, 4'b1111);
    chk("raw_waddr", ram_write_addr, 32'd4);
    chk("raw_hready_w", bus.HREADY, 1);
    ap(1'b1, IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    chk("raw_hrdata", bus.HRDATA, 32'h12345678);
    chk("raw_hready_r", bus.HREADY, 1);

    // Byte write to the top lane of word 4
    ap(1'b1, NONSEQ, 1'b1, 3'd0, 32'h13, 32'h0);
    ap(1'b1, IDLE, 1'b0, 3'd0, 32'h0, 32'hAB000000);
    chk("byte_we", ram_we, 4'b1000);
    chk("byte_waddr", ram_write_addr, 32'd4);
    ap(1'b1, NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    ap(1'b1, IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    chk("byte_hrdata", bus.HRDATA, 32'hAB345678);

    // Misaligned halfword
    ap(1'b1, NONSEQ, 1'b1, 3'd1, 32'h21, 32'h0);
    ap(1'b1, IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    chk("mis_c1_hready", bus.HREADY, 0);
    chk("mis_c1_hresp", bus.HRESP, 1);
    chk("mis_c1_we", ram_we, 4'b0000);
    ap(1'b1, IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    chk("mis_c2_hready", bus.HREADY, 1);
    chk("mis_c2_hresp", bus.HRESP, 1);
    chk("mis_c2_we", ram_we, 4'b0000);
    ap(1'b1, IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    chk("mis_c3_hresp", bus.HRESP, 0);

    // Oversize transfer, then address wrap
    ap(1'b1, NONSEQ, 1'b1, 3'd3, 32'h40, 32'h0);
    ap(1'b1, IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    chk("big_c1_hready", bus.HREADY, 0);
    chk("big_c1_hresp", bus.HRESP, 1);
    ap(1'b1, IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    chk("big_c2_hready", bus.HREADY, 1);
    chk("big_c2_hresp", bus.HRESP, 1);
    chk("big_we", ram_we, 4'b0000);
    ap(1'b1, NONSEQ, 1'b1, 3'd2, 32'h100, 32'h0);
    ap(1'b1, IDLE, 1'b0, 3'd0, 32'h0, 32'hCAFEF00D);
    chk("wrap_waddr", ram_write_addr, 32'd0);
    chk("wrap_we", ram_we, 4'b1111);

    // Reset during a write data phase
    ap(1'b1, NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0);
    @(posedge HCLK);
    #1 set_bus(1'b1, IDLE, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF);
    #2 HRESETn = 1'b0;
    #1;
    chk("rstw_we", ram_we, 4'b0000);
    chk("rstw_hready", bus.HREADY, 1);
    chk("rstw_hresp", bus.HRESP, 0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    set_bus(1'b1, NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    @(negedge HCLK);
    ap(1'b1, IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    chk("rstw_hrdata", bus.HRDATA, 32'hAB345678);
    chk("rstw_hready_r", bus.HREADY, 1);

    // Randomized traffic over a few words and their aliases
    repeat (3000) begin
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      off = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      a   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'(off);
      ap(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         sz, a, $urandom);
    end
    repeat (4) ap(1'b0, IDLE, 1'b0, 3'd0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
